// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-side partner of the fetch branch predictor. Decode pushes one prediction record per
// issued branch into an in-order queue. When execute resolves the oldest branch, the head
// record is popped and compared with the real outcome. The unit then issues a registered
// train/update beat, and on a mispredict a one-cycle flush carrying the corrected fetch PC.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   pred_valid/pc/taken/target/history  prediction record push from decode
//   res_valid/pc/taken/target        resolution of the oldest branch from execute
//   flush, redirect_pc               one-cycle flush pulse and corrected fetch PC
//   upd_valid/pc/taken/target/history   one-cycle predictor training beat
//   q_full, q_empty                  queue status, combinational from the pointers
//   err                              sticky protocol error
//   br_count, mp_count               saturating resolved-branch / mispredict counters
module branch_resolve_unit #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HIST_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [31:0]       pred_pc,
    input  logic              pred_taken,
    input  logic [31:0]       pred_target,
    input  logic [HIST_W-1:0] pred_history,
    input  logic              res_valid,
    input  logic [31:0]       res_pc,
    input  logic              res_taken,
    input  logic [31:0]       res_target,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              upd_valid,
    output logic [31:0]       upd_pc,
    output logic              upd_taken,
    output logic [31:0]       upd_target,
    output logic [HIST_W-1:0] upd_history,
    output logic              q_full,
    output logic              q_empty,
    output logic              err,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  mp_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e state_q, state_d;

    logic [31:0]       mem_pc     [DEPTH];
    logic              mem_taken  [DEPTH];
    logic [31:0]       mem_target [DEPTH];
    logic [HIST_W-1:0] mem_hist   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic        run, pop, push, pc_mismatch, mispredict, err_set;
    logic [31:0] head_pc, head_target;
    logic        head_taken;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head_pc     = mem_pc[rd_ptr_q[AW-1:0]];
    assign head_taken  = mem_taken[rd_ptr_q[AW-1:0]];
    assign head_target = mem_target[rd_ptr_q[AW-1:0]];

    // The FLUSH cycle is exactly the cycle the flush pulse is visible.
    assign flush = (state_q == StFlush);

    always_comb begin
        run         = (state_q == StRun);
        pop         = run && res_valid && !q_empty;
        pc_mismatch = pop && (head_pc != res_pc);
        mispredict  = pop && (pc_mismatch || (head_taken != res_taken) ||
                              (res_taken && (head_target != res_target)));
        // A full queue still accepts a push when the head leaves in the same cycle.
        push        = run && pred_valid && (!q_full || pop) && !mispredict;
        err_set     = (run && res_valid && q_empty) || pc_mismatch ||
                      (run && pred_valid && q_full && !pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (mispredict) begin
            // Everything younger than the mispredicted branch is wrong-path.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        end

        state_d = StRun;
        unique case (state_q)
            StRun:   state_d = mispredict ? StFlush : StRun;
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q[AW-1:0]]     <= pred_pc;
            mem_taken[wr_ptr_q[AW-1:0]]  <= pred_taken;
            mem_target[wr_ptr_q[AW-1:0]] <= pred_target;
            mem_hist[wr_ptr_q[AW-1:0]]   <= pred_history;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            upd_history <= '0;
            err         <= 1'b0;
            br_count    <= '0;
            mp_count    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            // Tables are never trained from a record whose PC does not match.
            upd_valid <= pop && !pc_mismatch;
            if (err_set) err <= 1'b1;
            if (pop) begin
                upd_pc      <= head_pc;
                upd_taken   <= res_taken;
                upd_target  <= res_target;
                upd_history <= mem_hist[rd_ptr_q[AW-1:0]];
                if (br_count != '1) br_count <= br_count + CNT_W'(1);
            end
            if (mispredict) begin
                redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
                if (mp_count != '1) mp_count <= mp_count + CNT_W'(1);
            end
        end
    end

endmodule
